mem_access: RTL and testbench

//   MEM-stage data-memory access unit. Sits between the EX/MEM register and the MEM/WB register.

---
 rtl/mem_access_pkg.sv | 25 ++
 rtl/mem_access_if.sv | 15 +
 rtl/mem_access_load_align_ext.sv | 29 ++
 rtl/mem_access.sv | 109 ++++++++++
 tb/tb_mem_access.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared widths, funct3 encodings and FSM state type for the MEM-stage access unit.
package mem_access_pkg;

  localparam int unsigned D_WIDTH   = 32;
  localparam int unsigned RF_SIZE   = 5;
  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned BE_WIDTH  = D_WIDTH / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory req/ready bus between the MEM stage (master) and data memory (slave).
interface mem_access_if;
  import mem_access_pkg::*;

  logic                req;
  logic                we;
  logic [D_WIDTH-1:0]  addr;
  logic [D_WIDTH-1:0]  wdata;
  logic [BE_WIDTH-1:0] be;
  logic                ready;
  logic [D_WIDTH-1:0]  rdata;

  modport master (output req, we, addr, wdata, be, input ready, rdata);
  modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/mem_access_load_align_ext.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module mem_access_load_align_ext
  import mem_access_pkg::*;
(
  input  logic [D_WIDTH-1:0] i_rdata,
  input  logic [1:0]         i_offset,
  input  logic [2:0]         i_funct3,
  output logic [D_WIDTH-1:0] o_data
);

  logic [4:0]         w_shamt;
  logic [D_WIDTH-1:0] w_shifted;

  assign w_shamt   = {i_offset, 3'b000};
  assign w_shifted = i_rdata >> w_shamt;

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_data = i_rdata;
      F3_BU:   o_data = {24'h000000, w_shifted[7:0]};
      F3_HU:   o_data = {16'h0000, w_shifted[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory access: request/stall FSM, store lanes, fault detection,
// load extension and a saturating wait-cycle counter.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   alu_out_mem,
  input  logic [D_WIDTH-1:0]   w_data_mem,
  input  logic [2:0]           funct3_mem,
  input  logic                 mem_read_mem,
  input  logic                 mem_write_mem,
  input  logic                 reg_write_mem,
  mem_access_if.master         dmem,
  output logic [D_WIDTH-1:0]   r_data_mem,
  output logic                 reg_write_out,
  output logic                 stall_mem,
  output logic                 fault_mem,
  output logic [CNT_WIDTH-1:0] wait_cnt
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_wait_cnt;

  logic                 w_access;
  logic                 w_misalign;
  logic                 w_fault;
  logic                 w_req;
  logic                 w_stall;
  logic                 w_complete_load;
  logic [BE_WIDTH-1:0]  w_store_be;
  logic [D_WIDTH-1:0]   w_store_wdata;
  logic [D_WIDTH-1:0]   w_load_ext;

  assign w_access   = mem_read_mem | mem_write_mem;
  assign w_misalign = ((funct3_mem[1:0] == 2'b01) && alu_out_mem[0]) ||
                      ((funct3_mem == F3_W) && (alu_out_mem[1:0] != 2'b00));
  assign w_fault    = ~rst & w_access & (~f3_legal(funct3_mem) | w_misalign);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // WAIT keeps the request up; the stalled EX/MEM register holds addr/data steady.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req = w_access & ~w_fault;
        if (w_req && !dmem.ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_req = 1'b1;
        if (dmem.ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (rst) w_req = 1'b0;
  end

  assign w_stall = w_req & ~dmem.ready;

  always_comb begin
    w_store_be    = 4'b1111;
    w_store_wdata = w_data_mem;
    case (funct3_mem[1:0])
      2'b00: begin
        w_store_be    = BE_WIDTH'(1) << alu_out_mem[1:0];
        w_store_wdata = {4{w_data_mem[7:0]}};
      end
      2'b01: begin
        w_store_be    = alu_out_mem[1] ? 4'b1100 : 4'b0011;
        w_store_wdata = {2{w_data_mem[15:0]}};
      end
      default: ;
    endcase
  end

  assign dmem.req   = w_req;
  assign dmem.we    = w_req & mem_write_mem;
  assign dmem.addr  = {alu_out_mem[D_WIDTH-1:2], 2'b00};
  assign dmem.wdata = w_store_wdata;
  assign dmem.be    = w_req ? (mem_write_mem ? w_store_be : 4'b1111) : 4'b0000;

  mem_access_load_align_ext u_load_align_ext (
    .i_rdata  (dmem.rdata),
    .i_offset (alu_out_mem[1:0]),
    .i_funct3 (funct3_mem),
    .o_data   (w_load_ext)
  );

  assign w_complete_load = w_req & dmem.ready & ~mem_write_mem;
  assign r_data_mem      = w_complete_load ? w_load_ext : '0;
  assign reg_write_out   = ~rst & reg_write_mem & ~w_stall & ~w_fault;
  assign stall_mem       = w_stall;
  assign fault_mem       = w_fault;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_wait_cnt <= '0;
    else if (w_stall && (r_wait_cnt != '1))  r_wait_cnt <= r_wait_cnt + CNT_WIDTH'(1);
  end

  assign wait_cnt = r_wait_cnt;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic [31:0] alu_out_mem;
  logic [31:0] w_data_mem;
  logic [2:0]  funct3_mem;
  logic        mem_read_mem;
  logic        mem_write_mem;
  logic        reg_write_mem;
  logic [31:0] r_data_mem;
  logic        reg_write_out;
  logic        stall_mem;
  logic        fault_mem;
  logic [15:0] wait_cnt;

  int total;
  int bad;

  mem_access_if bus ();

  mem_access dut (
    .clk           (clk),
    .rst           (rst),
    .alu_out_mem   (alu_out_mem),
    .w_data_mem    (w_data_mem),
    .funct3_mem    (funct3_mem),
    .mem_read_mem  (mem_read_mem),
    .mem_write_mem (mem_write_mem),
    .reg_write_mem (reg_write_mem),
    .dmem          (bus),
    .r_data_mem    (r_data_mem),
    .reg_write_out (reg_write_out),
    .stall_mem     (stall_mem),
    .fault_mem     (fault_mem),
    .wait_cnt      (wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic rw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic rdy, input logic [31:0] rdat);
    mem_read_mem  = rd;
    mem_write_mem = wr;
    reg_write_mem = rw;
    funct3_mem    = f3;
    alu_out_mem   = addr;
    w_data_mem    = wd;
    bus.ready     = rdy;
    bus.rdata     = rdat;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 1'b0, 32'h0);

    // Outputs held quiet while reset is asserted, even with a pending access.
    chk("rst_req",    32'(bus.req), 32'd0);
    chk("rst_be",     32'(bus.be), 32'd0);
    chk("rst_stall",  32'(stall_mem), 32'd0);
    chk("rst_rwout",  32'(reg_write_out), 32'd0);
    chk("rst_cnt",    32'(wait_cnt), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'h0);
    tick();

    // 1: zero-wait SW
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 32'h0);
    chk("sw_req",   32'(bus.req), 32'd1);
    chk("sw_we",    32'(bus.we), 32'd1);
    chk("sw_be",    32'(bus.be), 32'hF);
    chk("sw_wdata", bus.wdata, 32'hDEAD_BEEF);
    chk("sw_addr",  bus.addr, 32'h0000_0100);
    chk("sw_stall", 32'(stall_mem), 32'd0);
    tick();
    chk("sw_cnt",   32'(wait_cnt), 32'd0);

    // 2: byte/half loads with sign and zero extension
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0, 1'b1, 32'h8012_3456);
    chk("lb_data",  r_data_mem, 32'hFFFF_FF80);
    chk("lb_addr",  bus.addr, 32'h0000_0100);
    chk("lb_be",    32'(bus.be), 32'hF);
    chk("lb_we",    32'(bus.we), 32'd0);
    chk("lb_rwout", 32'(reg_write_out), 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'h0, 1'b1, 32'h8012_3456);
    chk("lbu_data", r_data_mem, 32'h0000_0080);
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0, 1'b1, 32'h8012_3456);
    chk("lh_data",  r_data_mem, 32'hFFFF_8012);
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0102, 32'h0, 1'b1, 32'h8012_3456);
    chk("lhu_data", r_data_mem, 32'h0000_8012);
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0, 1'b1, 32'h8012_3456);
    chk("lb1_data", r_data_mem, 32'h0000_0034);
    tick();

    // 3: store lanes and misaligned half fault
    drive(1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0000_1234, 1'b1, 32'h0);
    chk("sh_be",    32'(bus.be), 32'hC);
    chk("sh_wdata", bus.wdata, 32'h1234_1234);
    tick();
    drive(1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0000_00AB, 1'b1, 32'h0);
    chk("sb_be",    32'(bus.be), 32'h2);
    chk("sb_wdata", bus.wdata, 32'hABAB_ABAB);
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0, 1'b0, 32'h8012_3456);
    chk("lhmis_fault", 32'(fault_mem), 32'd1);
    chk("lhmis_req",   32'(bus.req), 32'd0);
    chk("lhmis_rwout", 32'(reg_write_out), 32'd0);
    chk("lhmis_stall", 32'(stall_mem), 32'd0);
    chk("lhmis_data",  r_data_mem, 32'd0);
    tick();
    chk("lhmis_cnt",   32'(wait_cnt), 32'd0);

    // 4: LW with three wait cycles
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h0, 1'b0, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lw_stall%0d", i), 32'(stall_mem), 32'd1);
      chk($sformatf("lw_addr%0d", i), bus.addr, 32'h0000_0200);
      chk($sformatf("lw_rwout%0d", i), 32'(reg_write_out), 32'd0);
      chk($sformatf("lw_data%0d", i), r_data_mem, 32'd0);
      tick();
    end
    bus.ready = 1'b1;
    bus.rdata = 32'hCAFE_F00D;
    #1;
    chk("lw_stall_end", 32'(stall_mem), 32'd0);
    chk("lw_req_end",   32'(bus.req), 32'd1);
    chk("lw_data",      r_data_mem, 32'hCAFE_F00D);
    chk("lw_rwout",     32'(reg_write_out), 32'd1);
    chk("lw_cnt",       32'(wait_cnt), 32'd3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'h0);
    chk("lw_idle_req",  32'(bus.req), 32'd0);
    tick();

    // 5: reset in the middle of WAIT
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0, 1'b0, 32'h0);
    tick();
    chk("wr_stall_pre", 32'(stall_mem), 32'd1);
    chk("wr_cnt_pre",   32'(wait_cnt), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("wr_req",   32'(bus.req), 32'd0);
    chk("wr_stall", 32'(stall_mem), 32'd0);
    chk("wr_cnt",   32'(wait_cnt), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    chk("wr_idle_req", 32'(bus.req), 32'd0);
    tick();
    chk("wr_idle_req2", 32'(bus.req), 32'd0);

    // 6: counter saturation, then illegal funct3
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h0, 1'b0, 32'h0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", 32'(wait_cnt), 32'h0000_FFFE);
    tick();
    chk("sat_ffff", 32'(wait_cnt), 32'h0000_FFFF);
    repeat (10) tick();
    chk("sat_hold",  32'(wait_cnt), 32'h0000_FFFF);
    chk("sat_stall", 32'(stall_mem), 32'd1);
    bus.ready = 1'b1;
    #1;
    chk("sat_done", 32'(stall_mem), 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'b011, 32'h0000_0400, 32'h0, 1'b1, 32'h0);
    chk("f3ill_fault", 32'(fault_mem), 32'd1);
    chk("f3ill_req",   32'(bus.req), 32'd0);
    chk("f3ill_rwout", 32'(reg_write_out), 32'd0);
    tick();
    chk("sat_final", 32'(wait_cnt), 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
